tx_fifo_rd_arbiter: RTL and testbench

//  Read-side scheduler for the TX async FIFOs, in the r_clk domain.

---
 rtl/tx_ctl_pkg.sv | 11 +
 rtl/tx_fifo_rd_arbiter_if.sv | 30 +++
 rtl/rr_pick.sv | 28 ++
 rtl/tx_fifo_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_tx_fifo_rd_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_ctl_pkg.sv
// Shared types and helpers for the TX control blocks.
// Used by the read-side arbiter and its handshake interface.
package tx_ctl_pkg;

  typedef enum logic {RD_IDLE, RD_BURST} rd_arb_state_e;

  function automatic int src_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_rd_arbiter_if.sv
// Output stream of the TX read arbiter: word, source index
// and a valid/ready handshake.
interface tx_fifo_rd_arbiter_if
  import tx_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  localparam int SW = src_w(NUM_REQ);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SW-1:0]         out_src;

  modport master (
    output out_valid,
    output out_data,
    output out_src,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_src,
    output out_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin finder: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SW'(j);
      end
    end
  end

endmodule

// File: rtl/tx_fifo_rd_arbiter.sv
// Read-side scheduler for the TX async FIFOs: round-robin bursts
// into a 2-entry output buffer with a valid/ready stream.
module tx_fifo_rd_arbiter
  import tx_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                          r_clk,
  input  logic                          rrst_n,
  input  logic                          en_i,
  input  logic [NUM_REQ-1:0]            rempty_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_i,
  output logic [NUM_REQ-1:0]            rinc_o,
  output logic                          busy_o,
  tx_fifo_rd_arbiter_if.master          out_if
);

  localparam int SW = src_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] TOP  = SW'(NUM_REQ - 1);

  rd_arb_state_e state, state_nx;
  logic [SW-1:0] rr_ptr, rr_ptr_nx;
  logic [SW-1:0] g, g_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic [SW-1:0] pick_idx;
  logic          pick_found;

  logic [DATA_WIDTH-1:0] head_d, tail_d, w_d;
  logic [SW-1:0]         head_s, tail_s;
  logic [1:0]            cnt;
  logic                  deq, space, pop;

  rr_pick #(
    .N  (NUM_REQ),
    .SW (SW)
  ) u_pick (
    .req   (~rempty_i),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign deq   = out_if.out_valid & out_if.out_ready;
  assign space = (cnt < 2'd2) | ((cnt == 2'd2) & deq);
  assign pop   = (state == RD_BURST) & en_i
               & ~rempty_i[g] & space;
  assign w_d   = rdata_i[int'(g)*DATA_WIDTH +: DATA_WIDTH];

  assign rinc_o = pop ? (NUM_REQ'(1) << g) : '0;
  assign busy_o = (state == RD_BURST) | (cnt != 2'd0);

  assign out_if.out_valid = (cnt != 2'd0);
  assign out_if.out_data  = head_d;
  assign out_if.out_src   = head_s;

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    g_nx      = g;
    bcnt_nx   = bcnt;
    unique case (state)
      RD_IDLE: begin
        if (en_i & pick_found) begin
          g_nx     = pick_idx;
          bcnt_nx  = '0;
          state_nx = RD_BURST;
        end
      end
      RD_BURST: begin
        if (pop) bcnt_nx = bcnt + 1'b1;
        if ((pop & (bcnt == LAST))
            | rempty_i[g] | ~en_i) begin
          state_nx  = RD_IDLE;
          rr_ptr_nx = (g == TOP) ? '0 : g + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state  <= RD_IDLE;
      rr_ptr <= '0;
      g      <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      g      <= g_nx;
      bcnt   <= bcnt_nx;
    end
  end

  // Head always holds the oldest word; tail only fills when head is busy.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_d <= '0;
      head_s <= '0;
      tail_d <= '0;
      tail_s <= '0;
      cnt    <= 2'd0;
    end else begin
      unique case (cnt)
        2'd0: begin
          if (pop) begin
            head_d <= w_d;
            head_s <= g;
          end
        end
        2'd1: begin
          if (pop & deq) begin
            head_d <= w_d;
            head_s <= g;
          end else if (pop) begin
            tail_d <= w_d;
            tail_s <= g;
          end
        end
        default: begin
          if (deq) begin
            head_d <= tail_d;
            head_s <= tail_s;
            if (pop) begin
              tail_d <= w_d;
              tail_s <= g;
            end
          end
        end
      endcase
      cnt <= cnt + {1'b0, pop} - {1'b0, deq};
    end
  end

  a_no_pop_empty: assert property (
    @(posedge r_clk) disable iff (!rrst_n)
    (rinc_o & rempty_i) == '0
  );

endmodule

// File: tb/tb_tx_fifo_rd_arbiter.sv
// Directed bench for tx_fifo_rd_arbiter: FIFO models, per-cycle
// vector table and stream scoreboard for multi-cycle cases.
module tb_tx_fifo_rd_arbiter;

  logic        r_clk = 1'b0;
  logic        rrst_n;
  logic        en_i;
  logic [1:0]  rempty_i;
  logic [63:0] rdata_i;
  logic [1:0]  rinc_o;
  logic        busy_o;

  always #5 r_clk = ~r_clk;

  tx_fifo_rd_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(2)) oif ();

  tx_fifo_rd_arbiter #(
    .DATA_WIDTH (32),
    .NUM_REQ    (2),
    .MAX_BURST  (4)
  ) dut (
    .r_clk    (r_clk),
    .rrst_n   (rrst_n),
    .en_i     (en_i),
    .rempty_i (rempty_i),
    .rdata_i  (rdata_i),
    .rinc_o   (rinc_o),
    .busy_o   (busy_o),
    .out_if   (oif)
  );

  logic [31:0] mem [2][256];
  int wr [2] = '{0, 0};
  int rd [2] = '{0, 0};
  int bad_rinc = 0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rempty_i[i]         = (wr[i] == rd[i]);
      rdata_i[i*32 +: 32] = mem[i][rd[i] % 256];
    end
  end

  always @(posedge r_clk) begin
    for (int i = 0; i < 2; i++)
      if (rinc_o[i]) rd[i] <= rd[i] + 1;
    if (rrst_n && ((rinc_o & rempty_i) != 2'b00))
      bad_rinc <= bad_rinc + 1;
  end

  logic [31:0] got_d [$];
  logic        got_s [$];
  logic [31:0] exp_d [$];
  logic        exp_s [$];

  always @(posedge r_clk) begin
    if (rrst_n && oif.out_valid && oif.out_ready) begin
      got_d.push_back(oif.out_data);
      got_s.push_back(oif.out_src);
    end
  end

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(int f, logic [31:0] d);
    mem[f][wr[f] % 256] = d;
    wr[f]++;
  endtask

  task automatic expect_w(logic s, logic [31:0] d);
    exp_s.push_back(s);
    exp_d.push_back(d);
  endtask

  task automatic check_seq(string nm, int base, int budget);
    int k;
    int n;
    k = 0;
    n = exp_d.size();
    while (got_d.size() < base + n && k < budget) begin
      @(negedge r_clk);
      k++;
    end
    chk({nm, "_count"}, 32'(got_d.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_d.size()) begin
        chk($sformatf("%s_d%0d", nm, i), got_d[base+i], exp_d[i]);
        chk($sformatf("%s_s%0d", nm, i),
            32'(got_s[base+i]), 32'(exp_s[i]));
      end
    end
    exp_d.delete();
    exp_s.delete();
  endtask

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic [1:0]  rinc;
    logic        ov;
    logic [31:0] data;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(logic [1:0] r, logic v,
                              logic [31:0] d, logic b);
    return '{en: 1'b1, rdy: 1'b1, rinc: r, ov: v, data: d, busy: b};
  endfunction

  vec_t tv [16];

  initial begin
    int base;
    int p;

    // single FIFO0 with 10 words: bursts 4,4,2 with one idle gap each
    tv[0]  = mk(2'b00, 1'b0, 32'h0,   1'b0);
    tv[1]  = mk(2'b01, 1'b0, 32'h0,   1'b1);
    tv[2]  = mk(2'b01, 1'b1, 32'h100, 1'b1);
    tv[3]  = mk(2'b01, 1'b1, 32'h101, 1'b1);
    tv[4]  = mk(2'b01, 1'b1, 32'h102, 1'b1);
    tv[5]  = mk(2'b00, 1'b1, 32'h103, 1'b1);
    tv[6]  = mk(2'b01, 1'b0, 32'h0,   1'b1);
    tv[7]  = mk(2'b01, 1'b1, 32'h104, 1'b1);
    tv[8]  = mk(2'b01, 1'b1, 32'h105, 1'b1);
    tv[9]  = mk(2'b01, 1'b1, 32'h106, 1'b1);
    tv[10] = mk(2'b00, 1'b1, 32'h107, 1'b1);
    tv[11] = mk(2'b01, 1'b0, 32'h0,   1'b1);
    tv[12] = mk(2'b01, 1'b1, 32'h108, 1'b1);
    tv[13] = mk(2'b00, 1'b1, 32'h109, 1'b1);
    tv[14] = mk(2'b00, 1'b0, 32'h0,   1'b0);
    tv[15] = mk(2'b00, 1'b0, 32'h0,   1'b0);

    rrst_n        = 1'b0;
    en_i          = 1'b0;
    oif.out_ready = 1'b0;
    repeat (2) @(negedge r_clk);
    #1;
    chk("por_rinc",  32'(rinc_o), 32'h0);
    chk("por_valid", 32'(oif.out_valid), 32'h0);
    chk("por_data",  oif.out_data, 32'h0);
    chk("por_src",   32'(oif.out_src), 32'h0);
    chk("por_busy",  32'(busy_o), 32'h0);
    @(negedge r_clk);
    rrst_n = 1'b1;
    @(negedge r_clk);

    for (int k = 0; k < 10; k++) push(0, 32'h100 + 32'(k));
    for (int i = 0; i < 16; i++) begin
      en_i          = tv[i].en;
      oif.out_ready = tv[i].rdy;
      #1;
      chk($sformatf("c%0d_rinc", i), 32'(rinc_o), 32'(tv[i].rinc));
      chk($sformatf("c%0d_valid", i), 32'(oif.out_valid), 32'(tv[i].ov));
      chk($sformatf("c%0d_busy", i), 32'(busy_o), 32'(tv[i].busy));
      if (tv[i].ov) begin
        chk($sformatf("c%0d_data", i), oif.out_data, tv[i].data);
        chk($sformatf("c%0d_src", i), 32'(oif.out_src), 32'h0);
      end
      @(negedge r_clk);
    end

    // reset in the middle of a FIFO1 burst (rr_ptr is 1 here)
    for (int k = 0; k < 10; k++) push(1, 32'h2fe + 32'(k));
    repeat (3) @(negedge r_clk);
    #1;
    chk("rst_pre_rinc", 32'(rinc_o), 32'h2);
    rrst_n = 1'b0;
    #1;
    chk("rst_rinc",  32'(rinc_o), 32'h0);
    chk("rst_valid", 32'(oif.out_valid), 32'h0);
    chk("rst_busy",  32'(busy_o), 32'h0);
    chk("rst_data",  oif.out_data, 32'h0);
    chk("rst_left1", 32'(wr[1] - rd[1]), 32'd8);
    en_i = 1'b0;
    @(negedge r_clk);
    rrst_n = 1'b1;
    @(negedge r_clk);

    // round-robin restart from FIFO0 although FIFO1 is non-empty
    for (int k = 0; k < 8; k++) push(0, 32'h200 + 32'(k));
    base = got_d.size();
    en_i = 1'b1;
    #1;
    chk("rr_idle_rinc", 32'(rinc_o), 32'h0);
    @(negedge r_clk);
    #1;
    chk("rr_first_grant", 32'(rinc_o), 32'h1);
    for (int k = 0; k < 16; k++) begin
      p = k / 4;
      expect_w(1'(p % 2), ((p % 2) != 0 ? 32'h300 : 32'h200)
               + 32'((p / 2) * 4 + k % 4));
    end
    check_seq("rr", base, 200);
    repeat (2) @(negedge r_clk);

    // backpressure: ready low for 5 cycles from an idle start
    oif.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(0, 32'h400 + 32'(k));
    p    = rd[0];
    base = got_d.size();
    repeat (5) @(negedge r_clk);
    #1;
    chk("bp_pops",  32'(rd[0] - p), 32'd2);
    chk("bp_rinc",  32'(rinc_o), 32'h0);
    chk("bp_valid", 32'(oif.out_valid), 32'h1);
    chk("bp_head",  oif.out_data, 32'h400);
    chk("bp_busy",  32'(busy_o), 32'h1);
    oif.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_w(1'b0, 32'h400 + 32'(k));
    check_seq("bp", base, 100);
    repeat (2) @(negedge r_clk);

    // FIFO1 empties after 2 pops, grant moves to FIFO0
    push(1, 32'h600);
    push(1, 32'h601);
    for (int k = 0; k < 3; k++) push(0, 32'h500 + 32'(k));
    base = got_d.size();
    expect_w(1'b1, 32'h600);
    expect_w(1'b1, 32'h601);
    for (int k = 0; k < 3; k++) expect_w(1'b0, 32'h500 + 32'(k));
    check_seq("emp", base, 100);
    repeat (2) @(negedge r_clk);

    // en_i dropped mid-burst on FIFO1, re-enable resumes at FIFO0
    for (int k = 0; k < 6; k++) begin
      push(0, 32'h700 + 32'(k));
      push(1, 32'h800 + 32'(k));
    end
    base = got_d.size();
    repeat (3) @(negedge r_clk);
    en_i = 1'b0;
    p    = rd[0] + rd[1];
    repeat (4) @(negedge r_clk);
    #1;
    chk("en_pops",  32'(rd[0] + rd[1] - p), 32'd0);
    chk("en_valid", 32'(oif.out_valid), 32'h0);
    chk("en_busy",  32'(busy_o), 32'h0);
    chk("en_drain", 32'(got_d.size() - base), 32'd2);
    en_i = 1'b1;
    #1;
    chk("en_idle_rinc", 32'(rinc_o), 32'h0);
    @(negedge r_clk);
    #1;
    chk("en_resume_grant", 32'(rinc_o), 32'h1);
    expect_w(1'b1, 32'h800);
    expect_w(1'b1, 32'h801);
    for (int k = 0; k < 4; k++) expect_w(1'b0, 32'h700 + 32'(k));
    for (int k = 2; k < 6; k++) expect_w(1'b1, 32'h800 + 32'(k));
    expect_w(1'b0, 32'h704);
    expect_w(1'b0, 32'h705);
    check_seq("en", base, 200);

    chk("rinc_on_empty", 32'(bad_rinc), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
